// File: rtl/dataflow_pkg.sv
// Shared definitions for the conditional-dataflow branch/merge blocks.
// Token buses carry the valid flag in their MSB, above the payload.
package dataflow_pkg;

    localparam logic STEER_LEFT  = 1'b0;
    localparam logic STEER_RIGHT = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Callers zero-extend the bus to 64 bits and pass the index of its MSB.
    function automatic logic tok_valid(input logic [63:0] bus, input logic [5:0] msb);
        return bus[msb];
    endfunction

endpackage

// File: rtl/simple_steer_token_slot.sv
// One-entry token register with a full flag.
// A load on the same edge as a drain leaves the slot full with the new token.
module token_slot
    import dataflow_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_drain,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic         o_ready,
    output logic [W-1:0] o_data
);

    slot_state_t  r_state;
    logic [W-1:0] r_data;

    // Slot occupancy and payload; load wins over drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SLOT_EMPTY;
            r_data  <= {W{1'b0}};
        end else if (i_load) begin
            r_state <= SLOT_FULL;
            r_data  <= i_data;
        end else if (i_drain) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= r_state;
        end
    end

    assign o_full  = (r_state == SLOT_FULL);
    assign o_ready = !o_full || i_drain;
    // An empty slot presents zero payload so stale data never leaks out.
    assign o_data  = o_full ? r_data : {W{1'b0}};

endmodule

// File: rtl/simple_steer.sv
// Dataflow branch: pairs a data token with a steer token and routes it left or right.
// Optional per-side fire counters are enabled with SIMPLE_STEER_STATS_EN.
module simple_steer
    import dataflow_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH:0]   in_data,
    output logic             in_back_stop,
    input  logic [1:0]       steer,
    output logic             steer_back_stop,
    output logic [WIDTH:0]   left_data,
    input  logic             left_down_stop,
    output logic [WIDTH:0]   right_data,
    input  logic             right_down_stop
`ifdef SIMPLE_STEER_STATS_EN
    ,
    output logic [15:0]      left_count,
    output logic [15:0]      right_count
`endif
);

    logic             w_d_full, w_d_ready, w_d_load;
    logic             w_s_full, w_s_ready, w_s_load, w_s_dir;
    logic             w_l_full, w_l_ready, w_l_drain;
    logic             w_r_full, w_r_ready, w_r_drain;
    logic             w_fire, w_fire_l, w_fire_r;
    logic [WIDTH-1:0] w_d_data, w_l_data, w_r_data;

    assign w_l_drain = w_l_full && !left_down_stop;
    assign w_r_drain = w_r_full && !right_down_stop;

    // A stalled target holds both D and S even when the other side is free.
    assign w_fire   = w_d_full && w_s_full &&
                      ((w_s_dir == STEER_RIGHT) ? w_r_ready : w_l_ready);
    assign w_fire_l = w_fire && (w_s_dir == STEER_LEFT);
    assign w_fire_r = w_fire && (w_s_dir == STEER_RIGHT);

    assign w_d_load = tok_valid(64'(in_data), 6'(WIDTH)) && w_d_ready;
    assign w_s_load = steer[1] && w_s_ready;

    assign in_back_stop    = !w_d_ready;
    assign steer_back_stop = !w_s_ready;
    assign left_data       = {w_l_full, w_l_data};
    assign right_data      = {w_r_full, w_r_data};

    token_slot #(.W(WIDTH)) u_d_slot (
        .clk(clk), .reset(reset), .i_load(w_d_load), .i_drain(w_fire),
        .i_data(in_data[WIDTH-1:0]), .o_full(w_d_full), .o_ready(w_d_ready), .o_data(w_d_data)
    );

    token_slot #(.W(1)) u_s_slot (
        .clk(clk), .reset(reset), .i_load(w_s_load), .i_drain(w_fire),
        .i_data(steer[0]), .o_full(w_s_full), .o_ready(w_s_ready), .o_data(w_s_dir)
    );

    token_slot #(.W(WIDTH)) u_l_slot (
        .clk(clk), .reset(reset), .i_load(w_fire_l), .i_drain(w_l_drain),
        .i_data(w_d_data), .o_full(w_l_full), .o_ready(w_l_ready), .o_data(w_l_data)
    );

    token_slot #(.W(WIDTH)) u_r_slot (
        .clk(clk), .reset(reset), .i_load(w_fire_r), .i_drain(w_r_drain),
        .i_data(w_d_data), .o_full(w_r_full), .o_ready(w_r_ready), .o_data(w_r_data)
    );

`ifdef SIMPLE_STEER_STATS_EN
    logic [15:0] r_left_count;
    logic [15:0] r_right_count;

    // Per-side fire counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_left_count  <= 16'h0000;
            r_right_count <= 16'h0000;
        end else if (w_fire_l) begin
            r_left_count  <= r_left_count + 16'd1;
        end else if (w_fire_r) begin
            r_right_count <= r_right_count + 16'd1;
        end else begin
            r_left_count  <= r_left_count;
        end
    end

    assign left_count  = r_left_count;
    assign right_count = r_right_count;
`endif

endmodule

// File: tb/tb_simple_steer.sv
// Scoreboard bench for simple_steer: directed tokens queue their expected outputs,
// a monitor pops and compares on every output transfer.
module tb_simple_steer;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] in_data;
    logic       in_back_stop;
    logic [1:0] steer;
    logic       steer_back_stop;
    logic [8:0] left_data;
    logic       left_down_stop;
    logic [8:0] right_data;
    logic       right_down_stop;
`ifdef SIMPLE_STEER_STATS_EN
    logic [15:0] left_count;
    logic [15:0] right_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] q_left[$];
    logic [8:0] q_right[$];

    simple_steer #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_back_stop(in_back_stop),
        .steer(steer), .steer_back_stop(steer_back_stop),
        .left_data(left_data), .left_down_stop(left_down_stop),
        .right_data(right_data), .right_down_stop(right_down_stop)
`ifdef SIMPLE_STEER_STATS_EN
        , .left_count(left_count), .right_count(right_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every output transfer must match the head of its queue.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && left_data[8] === 1'b1 && left_down_stop === 1'b0) begin
                n_tests++;
                if (q_left.size() == 0) begin
                    n_fail++;
                    $display("FAIL left_unexpected: got %h expected none", left_data);
                end else begin
                    e = q_left.pop_front();
                    if (left_data !== e) begin
                        n_fail++;
                        $display("FAIL left_order: got %h expected %h", left_data, e);
                    end
                end
            end
            if (reset === 1'b0 && right_data[8] === 1'b1 && right_down_stop === 1'b0) begin
                n_tests++;
                if (q_right.size() == 0) begin
                    n_fail++;
                    $display("FAIL right_unexpected: got %h expected none", right_data);
                end else begin
                    e = q_right.pop_front();
                    if (right_data !== e) begin
                        n_fail++;
                        $display("FAIL right_order: got %h expected %h", right_data, e);
                    end
                end
            end
        end
    end

    task automatic present(input logic dir, input logic [7:0] p);
        in_data = {1'b1, p};
        steer   = {1'b1, dir};
        if (dir) q_right.push_back({1'b1, p});
        else     q_left.push_back({1'b1, p});
    endtask

    // Hold data and steer until each is accepted; idle buses carry X payload.
    task automatic wait_accept(input string name);
        logic d_done = 1'b0;
        logic s_done = 1'b0;
        logic d_acc, s_acc;
        int   cyc = 0;
        while (!(d_done && s_done) && cyc < 40) begin
            @(negedge clk);
            d_acc = !d_done && !in_back_stop;
            s_acc = !s_done && !steer_back_stop;
            @(posedge clk);
            #1;
            if (d_acc) begin in_data = 9'b0_xxxx_xxxx; d_done = 1'b1; end
            if (s_acc) begin steer = 2'b0x; s_done = 1'b1; end
            cyc++;
        end
        if (!(d_done && s_done)) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got not accepted expected accepted", name);
        end
    endtask

    task automatic send(input logic dir, input logic [7:0] p, input string name);
        present(dir, p);
        wait_accept(name);
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while ((q_left.size() != 0 || q_right.size() != 0) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
        check({name, "_drained"}, 16'(q_left.size() + q_right.size()), 16'd0);
    endtask

    initial begin
        reset = 1'b1; in_data = 9'h000; steer = 2'b00;
        left_down_stop = 1'b0; right_down_stop = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_left", 16'(left_data), 16'h0000);
        check("rst_right", 16'(right_data), 16'h0000);
        check("rst_in_bs", 16'(in_back_stop), 16'h0000);
        check("rst_steer_bs", 16'(steer_back_stop), 16'h0000);

        // Single left token: visible only after the second edge, for one cycle.
        @(posedge clk); #1;
        present(1'b0, 8'hA5);
        @(posedge clk); #1;
        in_data = 9'b0_xxxx_xxxx; steer = 2'b0x;
        @(negedge clk); check("lat_edge1", 16'(left_data), 16'h0000);
        @(negedge clk); check("lat_edge2", 16'(left_data), 16'h01A5);
        @(negedge clk); check("lat_edge3", 16'(left_data), 16'h0000);
        wait_drain("lat");

        // Right path, then back-to-back tokens.
        send(1'b1, 8'h0F, "r0f");
        send(1'b1, 8'h01, "r01");
        send(1'b1, 8'h02, "r02");
        send(1'b1, 8'h03, "r03");
        wait_drain("b2b");

        // Back-pressure on the right output.
        right_down_stop = 1'b1;
        send(1'b1, 8'hAC, "bp_ac");
        send(1'b1, 8'hAD, "bp_ad");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_in_bs", 16'(in_back_stop), 16'h0001);
        check("bp_steer_bs", 16'(steer_back_stop), 16'h0001);
        check("bp_hold", 16'(right_data), 16'h01AC);
        @(posedge clk); #1;
        right_down_stop = 1'b0;
        wait_drain("bp");

        // Data arrives three cycles ahead of its steer.
        in_data = 9'h1B3;
        @(posedge clk); #1;
        in_data = 9'b0_xxxx_xxxx;
        repeat (3) begin
            @(negedge clk);
            check("early_in_bs", 16'(in_back_stop), 16'h0001);
            check("early_no_out", 16'(left_data[8]), 16'h0000);
            @(posedge clk); #1;
        end
        steer = 2'b10;
        q_left.push_back(9'h1B3);
        @(posedge clk); #1;
        steer = 2'b0x;
        @(negedge clk);
        check("early_not_yet", 16'(left_data[8]), 16'h0000);
        wait_drain("early");

        // Reset with L, D and S all full discards everything.
        left_down_stop = 1'b1;
        send(1'b0, 8'hC1, "rst_c1");
        send(1'b0, 8'hC2, "rst_c2");
        @(negedge clk);
        check("pre_rst_in_bs", 16'(in_back_stop), 16'h0001);
        @(posedge clk); #1;
        reset = 1'b1;
        q_left.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        left_down_stop = 1'b0;
        @(negedge clk);
        check("mid_rst_left", 16'(left_data), 16'h0000);
        check("mid_rst_in_bs", 16'(in_back_stop), 16'h0000);
        check("mid_rst_steer_bs", 16'(steer_back_stop), 16'h0000);
        repeat (5) @(negedge clk);

`ifdef SIMPLE_STEER_STATS_EN
        check("cnt_rst_left", left_count, 16'h0000);
        check("cnt_rst_right", right_count, 16'h0000);
        for (int i = 0; i < 5; i++) send(1'b0, 8'(8'h40 + i), "cnt_l");
        for (int i = 0; i < 3; i++) send(1'b1, 8'(8'h50 + i), "cnt_r");
        wait_drain("cnt");
        check("cnt_left", left_count, 16'd5);
        check("cnt_right", right_count, 16'd3);
        force dut.r_right_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_right_count;
        send(1'b1, 8'h77, "cnt_wrap");
        wait_drain("wrap");
        check("cnt_wrap", right_count, 16'h0000);
        check("cnt_left_kept", left_count, 16'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_steer.md
Name: simple_steer

Overview:
- Dataflow branch stage: consumes one data token and one steer token, and routes the data to the left or right output.
- Sits upstream of simple_arbiter, the merge stage, and feeds its left_data/right_data inputs. Together they form the branch/merge pair for conditional dataflow.
- Each input and each output has a one-entry token slot, so a full token is held without loss under back-pressure.

Parameters:
- WIDTH, 8, payload bits per data token. The data bus is WIDTH+1 bits: bit WIDTH is valid, bits WIDTH-1:0 are payload.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WIDTH+1  data token; bit WIDTH = valid.
- in_back_stop  out  1  high = in_data not accepted this cycle; producer must hold it.
- steer  in  2  steer token; bit1 = valid, bit0 = 1 for right, 0 for left.
- steer_back_stop  out  1  high = steer not accepted this cycle.
- left_data  out  WIDTH+1  token routed left; bit WIDTH = valid.
- left_down_stop  in  1  downstream cannot take left_data this cycle.
- right_data  out  WIDTH+1  token routed right.
- right_down_stop  in  1  downstream cannot take right_data this cycle.

Behaviour:
- Transfer rule on every channel: a token moves in a cycle where valid=1 and the receiver's stop=0. The producer holds the token unchanged while stop=1.
- Four slots, each EMPTY or FULL: D (data), S (steer), L (left out), R (right out).
- Reset: all slots EMPTY, so left_data and right_data read all-zero, in_back_stop=0 and steer_back_stop=0 on the first cycle after reset.
- Reset asserted mid-operation discards every held token on that edge. Reset has priority over all other events.
- Output drain:
  - L drains when L FULL and left_down_stop=0.
  - L is ready when it is EMPTY or draining this cycle. R behaves the same with right_down_stop.
- Fire: fire = D FULL and S FULL and the target slot (L if steer bit=0, else R) is ready.
  - On fire, D payload is written into the target slot with valid=1, and D and S both go EMPTY unless refilled the same edge.
  - The non-target slot is unaffected.
- Input acceptance:
  - in_back_stop = D FULL and not fire.
  - steer_back_stop = S FULL and not fire.
  - A slot that fires and accepts on the same edge stays FULL with the new token, giving full throughput.
  - Data and steer are accepted independently; neither waits for the other.
- Latency:
  - A token presented with its steer at edge N is captured at N.
  - It fires into the output slot at N+1 and is visible on the output after edge N+1.
  - Minimum latency is 2 edges. Sustained throughput is 1 token/cycle per path when down_stop=0.
- Simultaneous events:
  - Target slot draining and being refilled on the same edge keeps it FULL with the new token.
  - Both outputs may drain in the same cycle.
- Blocking: a stalled target blocks D and S even if the other output is free. Order is strictly in-order, with no bypass.
- Payload is never modified. An invalid input (valid bit=0) is ignored regardless of its payload bits, including X.
- Outputs and back_stops never go X after reset, even when input payloads are X.

Optional Feature:
- Macro: SIMPLE_STEER_STATS_EN.
- Defined:
  - Adds outputs left_count (out, 16) and right_count (out, 16).
  - Each counts fire events toward its side, resets to 0, and wraps 0xFFFF to 0x0000.
- Undefined: these ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Package dataflow_pkg:
  - STEER_LEFT=1'b0 and STEER_RIGHT=1'b1.
  - Function tok_valid(bus) returns the MSB of a token bus.
- Sub-module token_slot, instantiated four times:
  - A parameterised one-entry register with load, drain and full flag.
  - Ready = !full or drain.

Test Plan:
- Reset, then in_data=9'h1A5 with steer=2'b10 held one cycle, stops low -> left_data=9'h1A5 for exactly 1 cycle, 2 edges after presentation; right_data valid never set.
- steer=2'b11 with in_data=9'h10F -> right_data=9'h10F; left unchanged. Then back-to-back tokens 9'h101/9'h102/9'h103 to right -> one output per cycle, in order.
- right_down_stop=1, route 9'h1AC right, then a second token 9'h1AD right:
  - right_data holds 9'h1AC; D and S fill and in_back_stop=steer_back_stop=1; no token lost.
  - Release stop -> 9'h1AC then 9'h1AD.
- Data presented 3 cycles before steer=2'b10 -> data held in D (in_back_stop=1 afterwards); fires only after steer arrives.
- Reset asserted while L is FULL and D/S are FULL -> next cycle left_data valid=0, both back_stops=0, and no stale token emerges.
- With SIMPLE_STEER_STATS_EN: route 5 left, 3 right -> left_count=5, right_count=3. Preload a counter to 16'hFFFF via a forced sequence -> the next fire wraps it to 0.
